// File: rtl/lcd_arbiter.sv
// lcd_arbiter: sits in front of a single lcd_transmit byte transmitter.
// After reset it plays the fixed LCD init command sequence. It then shares the
// transmitter between two requesters with round-robin grant. Each transfer runs
// a start/done handshake with its own timeout, and the requester that was
// served gets a one-cycle ack.
module lcd_arbiter #(
   parameter logic [31:0] INIT_SEQ = 32'h3806_0E01,
   parameter int          TO_W     = 20,
   parameter int          TO_CYC   = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       cd0,
   output logic       ack0,
   input  logic       req1,
   input  logic [7:0] data1,
   input  logic       cd1,
   output logic       ack1,
   output logic [7:0] tx_data,
   output logic       tx_cd,
   output logic       tx_start,
   input  logic       tx_done,
   output logic       gnt,
   output logic       busy,
   output logic       init_done,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_GAP  = 2'd1,
      S_IDLE = 2'd2,
      S_XFER = 2'd3
   } state_t;

   state_t          state_r;
   logic [1:0]      idx_r;
   logic            last_r;
   logic [TO_W-1:0] cnt_r;

   logic            sel_s;
   logic            done_s;
   logic            to_hit_s;

   // The init byte at position i. Position 0 is the most significant byte.
   function automatic logic [7:0] init_byte(input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = INIT_SEQ[31:24];
         2'd1:    b = INIT_SEQ[23:16];
         2'd2:    b = INIT_SEQ[15:8];
         2'd3:    b = INIT_SEQ[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Pick a requester. On a tie, the one not served last wins.
   always_comb begin
      sel_s = 1'b0;
      if (req0 && req1) begin
         sel_s = ~last_r;
      end else if (req1) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
   end

   // tx_done only counts while a start is outstanding.
   // The timeout fires on the last allowed cycle.
   always_comb begin
      done_s   = tx_done && tx_start;
      to_hit_s = (cnt_r == TO_W'(TO_CYC - 1));
   end

   // Sequencer and arbiter FSM. Every output is registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= S_INIT;
         idx_r       <= 2'd0;
         last_r      <= 1'b1;
         cnt_r       <= '0;
         tx_data     <= 8'h00;
         tx_cd       <= 1'b0;
         tx_start    <= 1'b0;
         gnt         <= 1'b0;
         busy        <= 1'b0;
         init_done   <= 1'b0;
         timeout_err <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state_r)
            S_INIT: begin
               busy <= 1'b1;
               if (done_s || to_hit_s) begin
                  // A timeout still moves on to the next byte,
                  // so the init sequence always completes.
                  if (!done_s) begin
                     timeout_err <= 1'b1;
                  end else begin
                     timeout_err <= timeout_err;
                  end
                  tx_start <= 1'b0;
                  idx_r    <= idx_r + 2'd1;
                  if (idx_r == 2'd3) begin
                     init_done <= 1'b1;
                  end else begin
                     init_done <= init_done;
                  end
                  state_r <= S_GAP;
               end else begin
                  tx_start <= 1'b1;
                  tx_cd    <= 1'b0;
                  tx_data  <= init_byte(idx_r);
                  cnt_r    <= cnt_r + TO_W'(1);
               end
            end
            S_GAP: begin
               // tx_start is low for this one cycle, so lcd_transmit re-arms.
               // Requests are not looked at here.
               if (init_done) begin
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  busy     <= 1'b1;
                  tx_start <= 1'b1;
                  tx_cd    <= 1'b0;
                  tx_data  <= init_byte(idx_r);
                  cnt_r    <= '0;
                  state_r  <= S_INIT;
               end
            end
            S_IDLE: begin
               if (req0 || req1) begin
                  tx_data  <= sel_s ? data1 : data0;
                  tx_cd    <= sel_s ? cd1 : cd0;
                  gnt      <= sel_s;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
                  cnt_r    <= '0;
                  state_r  <= S_XFER;
               end else begin
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_XFER: begin
               busy <= 1'b1;
               if (done_s || to_hit_s) begin
                  // An aborted transfer is still acked, so the requester is not stuck.
                  if (!done_s) begin
                     timeout_err <= 1'b1;
                  end else begin
                     timeout_err <= timeout_err;
                  end
                  tx_start <= 1'b0;
                  if (gnt) begin
                     ack1 <= 1'b1;
                  end else begin
                     ack0 <= 1'b1;
                  end
                  last_r  <= gnt;
                  state_r <= S_GAP;
               end else begin
                  cnt_r <= cnt_r + TO_W'(1);
               end
            end
            default: begin
               tx_start <= 1'b0;
               cnt_r    <= '0;
               state_r  <= S_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_arbiter.sv
// Testbench for lcd_arbiter. A model of lcd_transmit answers each start with
// tx_done 5 cycles later; the model can be told to withhold tx_done. Directed
// stimulus pushes the expected transfers and acks into queues. Monitor
// processes pop those queues and compare whenever the DUT starts a byte or
// pulses an ack.
module tb_lcd_arbiter;

   typedef struct {
      logic [7:0] data;
      logic       cd;
      logic       is_req;
      logic       g;
      int         len;
      int         gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, cd0 = 1'b0, req1 = 1'b0, cd1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       ack0, ack1, tx_cd, tx_start, gnt, busy, init_done, timeout_err;
   logic [7:0] tx_data;
   logic       tx_done = 1'b0;
   logic       done_en = 1'b1;

   exp_t exp_q[$];
   int   ack_q[$];
   int   checks = 0;
   int   failures = 0;

   lcd_arbiter #(.TO_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .data0(data0), .cd0(cd0), .ack0(ack0),
      .req1(req1), .data1(data1), .cd1(cd1), .ack1(ack1),
      .tx_data(tx_data), .tx_cd(tx_cd), .tx_start(tx_start), .tx_done(tx_done),
      .gnt(gnt), .busy(busy), .init_done(init_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic c, input logic r, input logic g,
                       input int len, input int gap);
      exp_t e;
      e.data = d; e.cd = c; e.is_req = r; e.g = g; e.len = len; e.gap = gap;
      exp_q.push_back(e);
   endtask

   task automatic push_init();
      push(8'h38, 1'b0, 1'b0, 1'b0, 5, -1);
      push(8'h06, 1'b0, 1'b0, 1'b0, 5, 1);
      push(8'h0E, 1'b0, 1'b0, 1'b0, 5, 1);
      push(8'h01, 1'b0, 1'b0, 1'b0, 5, 1);
   endtask

   task automatic wait_ack(input int r);
      int   n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(posedge clk); #1;
         n++;
         seen = (r == 0) ? ack0 : ack1;
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL ack_timeout requester=%0d actual=none required=ack", r);
      end
   endtask

   task automatic send(input int r, input logic [7:0] d, input logic c, input logic keep);
      if (r == 0) begin data0 = d; cd0 = c; req0 = 1'b1; end
      else        begin data1 = d; cd1 = c; req1 = 1'b1; end
      wait_ack(r);
      if (!keep) begin
         if (r == 0) req0 = 1'b0;
         else        req1 = 1'b0;
      end
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!init_done && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      chk("init_done_set", {31'd0, init_done}, 32'd1);
   endtask

   // lcd_transmit model: tx_done is pulsed on the 5th cycle of a held start.
   initial begin : model
      int mc;
      mc = 0;
      forever begin
         @(negedge clk);
         tx_done = 1'b0;
         if (!rst || !tx_start) begin
            mc = 0;
         end else begin
            mc++;
            if (mc == 5 && done_en) tx_done = 1'b1;
         end
      end
   end

   // Start monitor: every rising tx_start is checked against the head of exp_q.
   initial begin : mon_start
      logic prev;
      logic cur_v;
      exp_t cur;
      int   len;
      int   gap;
      prev = 1'b0; cur_v = 1'b0; len = 0; gap = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev = 1'b0; cur_v = 1'b0; len = 0; gap = 0;
         end else begin
            if (tx_start && !prev) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_start actual=%0h required=none", tx_data);
                  cur_v = 1'b0;
               end else begin
                  cur = exp_q.pop_front();
                  cur_v = 1'b1;
                  chk("tx_data", {24'd0, tx_data}, {24'd0, cur.data});
                  chk("tx_cd", {31'd0, tx_cd}, {31'd0, cur.cd});
                  if (cur.is_req) begin
                     chk("gnt", {31'd0, gnt}, {31'd0, cur.g});
                     chk("req_after_init", {31'd0, init_done}, 32'd1);
                  end
                  if (cur.gap >= 0) chk("start_gap", gap, cur.gap);
               end
               len = 0;
            end
            if (tx_start) begin
               len++;
            end else if (prev) begin
               if (cur_v && cur.len >= 0) chk("start_len", len, cur.len);
               cur_v = 1'b0;
               gap = 1;
            end else begin
               gap++;
            end
            prev = tx_start;
         end
      end
   end

   // Ack monitor: every ack pulse is checked against the head of ack_q.
   initial begin : mon_ack
      int e;
      forever begin
         @(negedge clk);
         if (ack0 && ack1) begin
            checks++; failures++;
            $display("FAIL ack_both actual=11 required=one");
         end else if (ack0 || ack1) begin
            if (ack_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_ack actual=%0d required=none", ack1 ? 1 : 0);
            end else begin
               e = ack_q.pop_front();
               chk("ack_id", ack1 ? 32'd1 : 32'd0, e);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int n;
      // T1: reset state, then the init sequence.
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);
      chk("rst_acks", {30'd0, ack1, ack0}, 32'd0);
      chk("rst_gnt_err", {30'd0, gnt, timeout_err}, 32'd0);
      push_init();
      @(negedge clk) rst = 1'b1;
      wait_init();
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_tx_start", {31'd0, tx_start}, 32'd0);

      // T3: both requesters held, so the grants must alternate 0,1,0,1.
      push(8'h41, 1'b1, 1'b1, 1'b0, 5, -1);
      push(8'h42, 1'b0, 1'b1, 1'b1, 5, -1);
      push(8'h43, 1'b0, 1'b1, 1'b0, 5, -1);
      push(8'h44, 1'b1, 1'b1, 1'b1, 5, -1);
      ack_q.push_back(0); ack_q.push_back(1); ack_q.push_back(0); ack_q.push_back(1);
      fork
         begin send(0, 8'h41, 1'b1, 1'b1); send(0, 8'h43, 1'b0, 1'b0); end
         begin send(1, 8'h42, 1'b0, 1'b1); send(1, 8'h44, 1'b1, 1'b0); end
      join
      repeat (10) @(posedge clk);

      // T2: one data byte from requester 0; it must be sent once only.
      push(8'h48, 1'b1, 1'b1, 1'b0, 5, -1);
      ack_q.push_back(0);
      send(0, 8'h48, 1'b1, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("t2_sent_once", exp_q.size(), 32'd0);

      // T5: tx_done withheld. The transfer aborts after 16 cycles,
      // still acks, and sets the sticky error.
      done_en = 1'b0;
      push(8'h55, 1'b0, 1'b1, 1'b0, 16, -1);
      ack_q.push_back(0);
      send(0, 8'h55, 1'b0, 1'b0);
      chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
      done_en = 1'b1;
      repeat (3) @(posedge clk);
      push(8'h4A, 1'b1, 1'b1, 1'b1, 5, -1);
      ack_q.push_back(1);
      send(1, 8'h4A, 1'b1, 1'b0);
      chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

      // T6: reset mid-transfer. Outputs clear at once and no ack is given.
      repeat (3) @(posedge clk);
      push(8'h77, 1'b0, 1'b1, 1'b0, -1, -1);
      data0 = 8'h77; cd0 = 1'b0; req0 = 1'b1;
      n = 0;
      while (!tx_start && n < 50) begin @(posedge clk); #1; n++; end
      chk("t6_started", {31'd0, tx_start}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("t6_tx_start", {31'd0, tx_start}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_acks", {30'd0, ack1, ack0}, 32'd0);
      chk("t6_flags", {29'd0, gnt, init_done, timeout_err}, 32'd0);
      chk("t6_tx_data", {24'd0, tx_data}, 32'd0);
      req0 = 1'b0;

      // T4: request during init, served only after the init sequence.
      data1 = 8'h31; cd1 = 1'b1; req1 = 1'b1;
      push_init();
      push(8'h31, 1'b1, 1'b1, 1'b1, 5, -1);
      ack_q.push_back(1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      wait_ack(1);
      req1 = 1'b0;
      chk("t4_init_done", {31'd0, init_done}, 32'd1);

      repeat (20) @(posedge clk);
      #1;
      chk("exp_q_drained", exp_q.size(), 32'd0);
      chk("ack_q_drained", ack_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
